// File: rtl/program_counter_unit.sv
// Program counter with configurable width/step, scaled relative branches, stall and
// an optional return-address stack built only when PCU_RAS_EN is defined.
module program_counter_unit #(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  K_WIDTH      = 32,
    parameter int                  STEP         = 4,
    parameter int                  OFFSET_SHIFT = 2,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b0}},
    parameter int                  RAS_DEPTH    = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          PC_FS,
    input  logic                stall,
    input  logic [K_WIDTH-1:0]  k,
    input  logic [PC_WIDTH-1:0] in_a,
    input  logic                clear_err,
    output logic [PC_WIDTH-1:0] PC_out,
    output logic [PC_WIDTH-1:0] PC_plus,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_overflow,
    output logic                ras_underflow
);

    typedef enum logic [2:0] {
        FS_HOLD     = 3'b000,
        FS_INC      = 3'b001,
        FS_REL      = 3'b010,
        FS_JMP      = 3'b011,
        FS_CALL_REL = 3'b100,
        FS_RET      = 3'b101,
        FS_CALL_REG = 3'b110,
        FS_RSVD     = 3'b111
    } pc_fs_e;

    if (RAS_DEPTH < 2) begin : g_depth_check
        $error("program_counter_unit: RAS_DEPTH must be at least 2");
    end

    pc_fs_e              fs_s;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_plus_s;
    logic [PC_WIDTH-1:0] k_ext_s;
    logic [PC_WIDTH-1:0] rel_tgt_s;
    logic                ovf_q;
    logic                ovf_d;
    logic                unf_q;
    logic                unf_d;
    logic                ovf_evt_s;
    logic                unf_evt_s;
    logic                ras_empty_s;
    logic                ras_full_s;

    assign fs_s      = pc_fs_e'(PC_FS);
    assign pc_plus_s = pc_q + PC_WIDTH'(STEP);
    assign k_ext_s   = PC_WIDTH'($signed(k));
    assign rel_tgt_s = pc_q + (k_ext_s << OFFSET_SHIFT);

`ifdef PCU_RAS_EN
    localparam int                 PTR_W    = $clog2(RAS_DEPTH);
    localparam int                 CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(RAS_DEPTH - 1);

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_d;
    logic [PTR_W-1:0]    ptr_inc_s;
    logic [PTR_W-1:0]    ptr_dec_s;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [PC_WIDTH-1:0] ras_top_s;
    logic                push_s;
    logic                pop_s;

    // ptr_q is the next free slot; it wraps so a push while full overwrites the oldest entry
    assign ptr_inc_s   = (ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : ptr_q + PTR_W'(1);
    assign ptr_dec_s   = (ptr_q == {PTR_W{1'b0}}) ? PTR_LAST : ptr_q - PTR_W'(1);
    assign ras_top_s   = ras_mem[ptr_dec_s];
    assign ras_empty_s = (cnt_q == {CNT_W{1'b0}});
    assign ras_full_s  = (cnt_q == CNT_MAX);

    // Stack pointer and occupancy next state
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_s) begin
            ptr_d = ptr_inc_s;
            cnt_d = ras_full_s ? cnt_q : cnt_q + CNT_W'(1);
        end else if (pop_s) begin
            ptr_d = ptr_dec_s;
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            ptr_d = ptr_q;
            cnt_d = cnt_q;
        end
    end

    // Stack pointer and occupancy registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= {PTR_W{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack storage; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (push_s) begin
            ras_mem[ptr_q] <= pc_plus_s;
        end
    end
`else
    assign ras_empty_s = 1'b1;
    assign ras_full_s  = 1'b0;
`endif

    // Function decode: next PC plus stack push/pop requests and error events
    always_comb begin
        pc_d      = pc_q;
        ovf_evt_s = 1'b0;
        unf_evt_s = 1'b0;
`ifdef PCU_RAS_EN
        push_s    = 1'b0;
        pop_s     = 1'b0;
`endif
        if (stall) begin
            pc_d = pc_q;
        end else begin
            case (fs_s)
                FS_INC:      pc_d = pc_plus_s;
                FS_REL:      pc_d = rel_tgt_s;
                FS_JMP:      pc_d = in_a;
`ifdef PCU_RAS_EN
                FS_CALL_REL: begin
                    push_s    = 1'b1;
                    ovf_evt_s = ras_full_s;
                    pc_d      = rel_tgt_s;
                end
                FS_RET: begin
                    if (ras_empty_s) begin
                        unf_evt_s = 1'b1;
                        pc_d      = pc_q;
                    end else begin
                        pop_s = 1'b1;
                        pc_d  = ras_top_s;
                    end
                end
                FS_CALL_REG: begin
                    push_s    = 1'b1;
                    ovf_evt_s = ras_full_s;
                    pc_d      = in_a;
                end
`else
                FS_CALL_REL: pc_d = rel_tgt_s;
                FS_RET:      pc_d = in_a;
                FS_CALL_REG: pc_d = in_a;
`endif
                default:     pc_d = pc_q;
            endcase
        end
    end

    // A new error in the same cycle as clear_err keeps the flag set
    assign ovf_d = (ovf_q & ~clear_err) | ovf_evt_s;
    assign unf_d = (unf_q & ~clear_err) | unf_evt_s;

    // PC and sticky error flag registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VECTOR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign PC_out        = pc_q;
    assign PC_plus       = pc_plus_s;
    assign ras_empty     = ras_empty_s;
    assign ras_full      = ras_full_s;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Bench for program_counter_unit: directed scenarios plus random traffic checked against
// a queue-based reference model; follows the PCU_RAS_EN build of the design.
`timescale 1ns/1ps
module tb_program_counter_unit;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  PC_FS = 3'd0;
    logic        stall = 1'b0;
    logic [31:0] k = 32'd0;
    logic [31:0] in_a = 32'd0;
    logic        clear_err = 1'b0;
    logic [31:0] PC_out;
    logic [31:0] PC_plus;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;
    logic        ras_underflow;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    logic [31:0] m_stack[$];
    logic        m_ovf;
    logic        m_unf;

    program_counter_unit dut (
        .clock(clock), .reset(reset), .PC_FS(PC_FS), .stall(stall), .k(k), .in_a(in_a),
        .clear_err(clear_err), .PC_out(PC_out), .PC_plus(PC_plus), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_pc = 32'h0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_cycle(input logic [2:0] fs, input logic [31:0] kv, input logic [31:0] av,
                               input logic st, input logic clr);
        logic [31:0] link;
        logic [31:0] rel;
        logic        ovf_ev;
        logic        unf_ev;
        link   = m_pc + 32'd4;
        rel    = m_pc + kv * 32'd4;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        if (!st) begin
            case (fs)
                3'd1: m_pc = link;
                3'd2: m_pc = rel;
                3'd3: m_pc = av;
`ifdef PCU_RAS_EN
                3'd4, 3'd6: begin
                    ovf_ev = (m_stack.size() == DEPTH);
                    m_stack.push_back(link);
                    if (m_stack.size() > DEPTH) m_stack.delete(0);
                    m_pc = (fs == 3'd4) ? rel : av;
                end
                3'd5: begin
                    if (m_stack.size() == 0) unf_ev = 1'b1;
                    else m_pc = m_stack.pop_back();
                end
`else
                3'd4: m_pc = rel;
                3'd5, 3'd6: m_pc = av;
`endif
                default: ;
            endcase
        end
        m_ovf = (m_ovf && !clr) || ovf_ev;
        m_unf = (m_unf && !clr) || unf_ev;
    endtask

    function automatic logic exp_empty();
`ifdef PCU_RAS_EN
        return (m_stack.size() == 0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic exp_full();
`ifdef PCU_RAS_EN
        return (m_stack.size() == DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    task automatic apply(input logic [2:0] fs, input logic [31:0] kv, input logic [31:0] av,
                         input logic st, input logic clr);
        PC_FS = fs; k = kv; in_a = av; stall = st; clear_err = clr;
        @(posedge clock);
        model_cycle(fs, kv, av, st, clr);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        #12;
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", PC_out, 32'h0); end
        checks++; if (PC_plus !== 32'h4) begin errors++; $display("FAIL reset_plus got=%h exp=%h", PC_plus, 32'h4); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", ras_empty); end
        checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", ras_full); end
        checks++; if ({ras_overflow, ras_underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", ras_overflow, ras_underflow); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_increment();
        for (int i = 1; i <= 3; i++) begin
            apply(3'd1, 32'd0, 32'd0, 1'b0, 1'b0);
            checks++; if (PC_out !== 32'(4 * i)) begin errors++; $display("FAIL inc_pc step=%0d got=%h exp=%h", i, PC_out, 32'(4 * i)); end
        end
        checks++; if (PC_plus !== 32'd16) begin errors++; $display("FAIL inc_plus got=%h exp=%h", PC_plus, 32'd16); end
    endtask

    task automatic test_relative_wrap();
        apply(3'd3, 32'd0, 32'd8, 1'b0, 1'b0);
        apply(3'd2, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0);
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL rel_neg got=%h exp=%h", PC_out, 32'h0); end
        apply(3'd2, 32'h0000_0040, 32'd0, 1'b0, 1'b0);
        checks++; if (PC_out !== 32'h100) begin errors++; $display("FAIL rel_pos got=%h exp=%h", PC_out, 32'h100); end
        apply(3'd3, 32'd0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        apply(3'd1, 32'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL inc_wrap got=%h exp=%h", PC_out, 32'h0); end
    endtask

    task automatic test_call_return();
        logic e_after_call;
`ifdef PCU_RAS_EN
        e_after_call = 1'b0;
`else
        e_after_call = 1'b1;
`endif
        apply(3'd3, 32'd0, 32'h100, 1'b0, 1'b0);
        apply(3'd4, 32'h10, 32'd0, 1'b0, 1'b0);
        checks++; if (PC_out !== 32'h140) begin errors++; $display("FAIL call_pc got=%h exp=%h", PC_out, 32'h140); end
        checks++; if (ras_empty !== e_after_call) begin errors++; $display("FAIL call_empty got=%b exp=%b", ras_empty, e_after_call); end
        apply(3'd5, 32'd0, 32'h104, 1'b0, 1'b0);
        checks++; if (PC_out !== 32'h104) begin errors++; $display("FAIL ret_pc got=%h exp=%h", PC_out, 32'h104); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got=%b exp=1", ras_empty); end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < 5; i++) apply(3'd6, 32'd0, 32'h200 + 32'(16 * i), 1'b0, 1'b0);
        checks++; if (ras_full !== exp_full()) begin errors++; $display("FAIL ovf_full got=%b exp=%b", ras_full, exp_full()); end
        checks++; if (ras_overflow !== m_ovf) begin errors++; $display("FAIL ovf_flag got=%b exp=%b", ras_overflow, m_ovf); end
        for (int i = 0; i < 5; i++) begin
            apply(3'd5, 32'd0, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
            checks++; if (PC_out !== m_pc) begin errors++; $display("FAIL ret_seq%0d got=%h exp=%h", i, PC_out, m_pc); end
        end
`ifdef PCU_RAS_EN
        checks++; if (PC_out !== 32'h204) begin errors++; $display("FAIL ret_hold got=%h exp=%h", PC_out, 32'h204); end
`endif
        checks++; if (ras_underflow !== m_unf) begin errors++; $display("FAIL unf_flag got=%b exp=%b", ras_underflow, m_unf); end
        apply(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        checks++; if ({ras_overflow, ras_underflow} !== 2'b00) begin errors++; $display("FAIL clear_err got=%b%b exp=00", ras_overflow, ras_underflow); end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        apply(3'd6, 32'd0, 32'h300, 1'b0, 1'b0);
        held = m_pc;
        apply(3'd4, 32'h40, 32'd0, 1'b1, 1'b0);
        checks++; if (PC_out !== held) begin errors++; $display("FAIL stall_pc got=%h exp=%h", PC_out, held); end
        checks++; if (ras_empty !== exp_empty()) begin errors++; $display("FAIL stall_empty got=%b exp=%b", ras_empty, exp_empty()); end
        checks++; if ({ras_overflow, ras_underflow} !== 2'b00) begin errors++; $display("FAIL stall_flags got=%b%b exp=00", ras_overflow, ras_underflow); end
        apply(3'd5, 32'd0, 32'h3000, 1'b0, 1'b0);
        checks++; if (PC_out !== m_pc) begin errors++; $display("FAIL stall_ret got=%h exp=%h", PC_out, m_pc); end
    endtask

    task automatic test_reset_mid();
        apply(3'd6, 32'd0, 32'h400, 1'b0, 1'b0);
        apply(3'd6, 32'd0, 32'h500, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL rstmid_pc got=%h exp=%h", PC_out, 32'h0); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%b exp=1", ras_empty); end
        @(negedge clock);
        reset = 1'b1;
        apply(3'd5, 32'd0, 32'h600, 1'b0, 1'b0);
        checks++; if (ras_underflow !== m_unf) begin errors++; $display("FAIL rstmid_unf got=%b exp=%b", ras_underflow, m_unf); end
        checks++; if (PC_out !== m_pc) begin errors++; $display("FAIL rstmid_ret got=%h exp=%h", PC_out, m_pc); end
        apply(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [2:0]  fs;
        logic [31:0] kv;
        logic [31:0] av;
        logic        st;
        logic        clr;
        for (int n = 0; n < 400; n++) begin
            fs  = 3'($urandom_range(0, 7));
            kv  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 63)) - 32);
            av  = $urandom;
            st  = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 9) == 0);
            apply(fs, kv, av, st, clr);
            checks++; if (PC_out !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, PC_out, m_pc); end
            checks++; if (PC_plus !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_plus n=%0d got=%h exp=%h", n, PC_plus, m_pc + 32'd4); end
            checks++; if (ras_empty !== exp_empty()) begin errors++; $display("FAIL rnd_empty n=%0d got=%b exp=%b", n, ras_empty, exp_empty()); end
            checks++; if (ras_full !== exp_full()) begin errors++; $display("FAIL rnd_full n=%0d got=%b exp=%b", n, ras_full, exp_full()); end
            checks++; if (ras_overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, ras_overflow, m_ovf); end
            checks++; if (ras_underflow !== m_unf) begin errors++; $display("FAIL rnd_unf n=%0d got=%b exp=%b", n, ras_underflow, m_unf); end
        end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_relative_wrap();
        test_call_return();
        test_overflow_underflow();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
